math_axil_regs: RTL and testbench
=================================

Name: math_axil_regs

Overview:
AXI4-Lite slave register block for the math IP. It is the responder side of the S00_AXI bus that the master VIP bench drives.
- Four read/write 32-bit registers sit at 0x00–0x0C.
- A registered read-only arithmetic result register sits at 0x10, computed from those registers.
- It sits directly behind the S00_AXI port of the math IP wrapper.

Parameters:
C_S_AXI_DATA_WIDTH, 32, data bus width; only 32 supported.
C_S_AXI_ADDR_WIDTH, 5, byte address width; decode uses ADDR[4:2].

Ports:
S_AXI_ACLK  in  1  clock
S_AXI_ARESETN  in  1  synchronous active-low reset
S_AXI_AWADDR  in  5  write address
S_AXI_AWPROT  in  3  ignored
S_AXI_AWVALID  in  1  write address valid
S_AXI_AWREADY  out  1  write address ready
S_AXI_WDATA  in  32  write data
S_AXI_WSTRB  in  4  byte lane strobes
S_AXI_WVALID  in  1  write data valid
S_AXI_WREADY  out  1  write data ready
S_AXI_BRESP  out  2  write response
S_AXI_BVALID  out  1  write response valid
S_AXI_BREADY  in  1  write response ready
S_AXI_ARADDR  in  5  read address
S_AXI_ARPROT  in  3  ignored
S_AXI_ARVALID  in  1  read address valid
S_AXI_ARREADY  out  1  read address ready
S_AXI_RDATA  out  32  read data
S_AXI_RRESP  out  2  read response
S_AXI_RVALID  out  1  read data valid
S_AXI_RREADY  in  1  read data ready
result_o  out  32  current result register, for the core

Behaviour:
- Reset (S_AXI_ARESETN low at a rising edge): all READY/VALID outputs are 0, BRESP/RRESP/RDATA are 0, reg0–reg3 are 0, and result is 0.
- Reset mid-transaction drops any pending AW/W/B/AR/R state. No response is issued for it afterwards.
- Register map, indexed by ADDR[4:2]:
  - 0 = reg0 (operand A), RW
  - 1 = reg1 (operand B), RW
  - 2 = reg2 (scratch), RW
  - 3 = reg3 (op select, bits[1:0]), RW, full 32 bits stored
  - 4 = result, RO
  - 5–7 unmapped
  - ADDR[1:0] is ignored.
- Write channel:
  - AWREADY is high when no address is latched and BVALID=0.
  - WREADY is high when no data is latched and BVALID=0.
  - AW and W are accepted independently, in either order or in the same cycle, and each is latched.
  - In the cycle after both are latched, the register write occurs per WSTRB lane and BVALID rises. No AW/W is accepted while BVALID=1.
  - BVALID holds until BREADY; it clears on the edge where BVALID&&BREADY.
  - BRESP is OKAY (00) for addresses 0–3.
  - BRESP is SLVERR (10) for address 4 (RO) and for 5–7; no state changes in those cases.
- Read channel:
  - ARREADY is high when RVALID=0.
  - On the AR handshake edge, RDATA is loaded from the selected register and RVALID rises next cycle (1-cycle latency).
  - RVALID/RDATA hold until RREADY.
  - RRESP is OKAY for addresses 0–4. It is SLVERR with RDATA=0 for 5–7.
- Result register: computed and registered every cycle from the current reg0, reg1 and reg3[1:0]:
  - 0: A+B, mod 2^32
  - 1: A−B, mod 2^32
  - 2: low 32 bits of A*B
  - 3: A&B
  - Result therefore lags a register write by 1 cycle. A read accepted in the same cycle as the write's register update returns the old result.
- Simultaneous read and write of the same register in one cycle: the read returns the pre-write value.
- Read and write channels are fully independent; neither stalls the other.
- result_o always equals the result register.

Test Plan:
1. Write 0x1, 0x2, 0x3, 0x4 to 0x00/0x04/0x08/0x0C (WSTRB=0xF), then read back -> RDATA 0x1, 0x2, 0x3, 0x4, all RRESP=00 and BRESP=00.
2. reg0=0x5, reg1=0x7 with reg3 = 0, 1, 2, 3 in turn; read 0x10 after each -> 0xC, 0xFFFFFFFE, 0x23, 0x5; result_o matches.
3. Write 0xAABBCCDD to 0x08 with WSTRB=0x5 over prior 0x11223344 -> read gives 0x11BB33DD.
4. W presented 3 cycles before AW, with BREADY held low 4 cycles -> single write, BVALID stays high, AWREADY/WREADY stay low until BREADY; the next write is then accepted.
5. Write to 0x10 and to 0x14; read 0x18 -> BRESP=10 both times, result unchanged, RRESP=10 and RDATA=0.
6. Deassert S_AXI_ARESETN while BVALID=1 and RVALID=1 -> both are 0 one edge later, all registers read 0 after release, and no stale response appears.

Source files
------------

// File: rtl/math_axil_regs.sv
// -----------------------------------------------------------------------------
// math_axil_regs
// AXI4-Lite slave register block for the math IP.
//   0x00 reg0 : operand A         (RW)
//   0x04 reg1 : operand B         (RW)
//   0x08 reg2 : scratch           (RW)
//   0x0C reg3 : op select [1:0]   (RW, all 32 bits stored)
//   0x10 result                   (RO, registered every cycle)
//   0x14-0x1C unmapped            (SLVERR, reads return 0)
//
// Ports:
//   S_AXI_ACLK / S_AXI_ARESETN : clock, synchronous active-low reset
//   S_AXI_AW* / S_AXI_W* / S_AXI_B* : write address, data, response channels
//   S_AXI_AR* / S_AXI_R*            : read address, data channels
//   result_o                        : current result register, for the core
// -----------------------------------------------------------------------------
module math_axil_regs #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 5
) (
    input  logic                            S_AXI_ACLK,
    input  logic                            S_AXI_ARESETN,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
    input  logic [2:0]                      S_AXI_AWPROT,
    input  logic                            S_AXI_AWVALID,
    output logic                            S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
    input  logic                            S_AXI_WVALID,
    output logic                            S_AXI_WREADY,
    output logic [1:0]                      S_AXI_BRESP,
    output logic                            S_AXI_BVALID,
    input  logic                            S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
    input  logic [2:0]                      S_AXI_ARPROT,
    input  logic                            S_AXI_ARVALID,
    output logic                            S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
    output logic [1:0]                      S_AXI_RRESP,
    output logic                            S_AXI_RVALID,
    input  logic                            S_AXI_RREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   result_o
);

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    // Merge new data into an old word, one byte lane per strobe bit.
    function automatic logic [31:0] apply_strb(input logic [31:0] old_v,
                                               input logic [31:0] new_v,
                                               input logic [3:0]  strb);
        logic [31:0] r;
        for (int i = 0; i < 4; i++) begin
            r[i*8 +: 8] = strb[i] ? new_v[i*8 +: 8] : old_v[i*8 +: 8];
        end
        return r;
    endfunction

    // Keeps the READY outputs low while reset is asserted.
    logic        ready_en_q;

    logic        aw_valid_q;
    logic [2:0]  aw_idx_q;
    logic        w_valid_q;
    logic [31:0] w_data_q;
    logic [3:0]  w_strb_q;
    logic        bvalid_q;
    logic [1:0]  bresp_q;

    logic        rvalid_q;
    logic [1:0]  rresp_q;
    logic [31:0] rdata_q;

    logic [31:0] reg0_q, reg1_q, reg2_q, reg3_q;
    logic [31:0] result_q, result_d;

    logic        aw_hs_s, w_hs_s, ar_hs_s, commit_s;
    logic [31:0] rd_data_s;
    logic [1:0]  rd_resp_s;

    logic        unused_s;
    assign unused_s = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

    assign S_AXI_AWREADY = ready_en_q & ~aw_valid_q & ~bvalid_q;
    assign S_AXI_WREADY  = ready_en_q & ~w_valid_q  & ~bvalid_q;
    assign S_AXI_ARREADY = ready_en_q & ~rvalid_q;
    assign S_AXI_BVALID  = bvalid_q;
    assign S_AXI_BRESP   = bresp_q;
    assign S_AXI_RVALID  = rvalid_q;
    assign S_AXI_RRESP   = rresp_q;
    assign S_AXI_RDATA   = rdata_q;
    assign result_o      = result_q;

    assign aw_hs_s  = S_AXI_AWVALID & S_AXI_AWREADY;
    assign w_hs_s   = S_AXI_WVALID  & S_AXI_WREADY;
    assign ar_hs_s  = S_AXI_ARVALID & S_AXI_ARREADY;
    // Address and data both latched: update registers and raise BVALID.
    assign commit_s = aw_valid_q & w_valid_q;

    // Arithmetic result from the current operand and op-select registers.
    always_comb begin
        result_d = 32'h0000_0000;
        case (reg3_q[1:0])
            2'd0:    result_d = reg0_q + reg1_q;
            2'd1:    result_d = reg0_q - reg1_q;
            2'd2:    result_d = reg0_q * reg1_q;
            2'd3:    result_d = reg0_q & reg1_q;
            default: result_d = 32'h0000_0000;
        endcase
    end

    // Read mux: values sampled on the AR handshake edge are pre-write values.
    always_comb begin
        rd_data_s = 32'h0000_0000;
        rd_resp_s = RESP_OKAY;
        case (S_AXI_ARADDR[4:2])
            3'd0:    rd_data_s = reg0_q;
            3'd1:    rd_data_s = reg1_q;
            3'd2:    rd_data_s = reg2_q;
            3'd3:    rd_data_s = reg3_q;
            3'd4:    rd_data_s = result_q;
            default: rd_resp_s = RESP_SLVERR;
        endcase
    end

    // Write channel: independent AW/W latches, commit, and B response.
    always_ff @(posedge S_AXI_ACLK) begin
        if (!S_AXI_ARESETN) begin
            ready_en_q <= 1'b0;
            aw_valid_q <= 1'b0;
            aw_idx_q   <= 3'd0;
            w_valid_q  <= 1'b0;
            w_data_q   <= 32'h0000_0000;
            w_strb_q   <= 4'h0;
            bvalid_q   <= 1'b0;
            bresp_q    <= RESP_OKAY;
        end else begin
            ready_en_q <= 1'b1;
            if (aw_hs_s) begin
                aw_valid_q <= 1'b1;
                aw_idx_q   <= S_AXI_AWADDR[4:2];
            end
            if (w_hs_s) begin
                w_valid_q <= 1'b1;
                w_data_q  <= S_AXI_WDATA;
                w_strb_q  <= S_AXI_WSTRB;
            end
            if (commit_s) begin
                aw_valid_q <= 1'b0;
                w_valid_q  <= 1'b0;
                bvalid_q   <= 1'b1;
                bresp_q    <= (aw_idx_q < 3'd4) ? RESP_OKAY : RESP_SLVERR;
            end else if (bvalid_q && S_AXI_BREADY) begin
                bvalid_q <= 1'b0;
            end
        end
    end

    // Register file; writes to RO/unmapped indices are dropped.
    always_ff @(posedge S_AXI_ACLK) begin
        if (!S_AXI_ARESETN) begin
            reg0_q <= 32'h0000_0000;
            reg1_q <= 32'h0000_0000;
            reg2_q <= 32'h0000_0000;
            reg3_q <= 32'h0000_0000;
        end else if (commit_s) begin
            case (aw_idx_q)
                3'd0:    reg0_q <= apply_strb(reg0_q, w_data_q, w_strb_q);
                3'd1:    reg1_q <= apply_strb(reg1_q, w_data_q, w_strb_q);
                3'd2:    reg2_q <= apply_strb(reg2_q, w_data_q, w_strb_q);
                3'd3:    reg3_q <= apply_strb(reg3_q, w_data_q, w_strb_q);
                default: reg0_q <= reg0_q;
            endcase
        end
    end

    // Result register, refreshed every cycle (lags register writes by one).
    always_ff @(posedge S_AXI_ACLK) begin
        if (!S_AXI_ARESETN) begin
            result_q <= 32'h0000_0000;
        end else begin
            result_q <= result_d;
        end
    end

    // Read channel: load RDATA on AR handshake, hold until RREADY.
    always_ff @(posedge S_AXI_ACLK) begin
        if (!S_AXI_ARESETN) begin
            rvalid_q <= 1'b0;
            rresp_q  <= RESP_OKAY;
            rdata_q  <= 32'h0000_0000;
        end else if (ar_hs_s) begin
            rvalid_q <= 1'b1;
            rresp_q  <= rd_resp_s;
            rdata_q  <= rd_data_s;
        end else if (rvalid_q && S_AXI_RREADY) begin
            rvalid_q <= 1'b0;
        end
    end

endmodule

// File: tb/tb_math_axil_regs.sv
module tb_math_axil_regs;

    logic        clk = 1'b0;
    logic        arst_n;
    logic [4:0]  awaddr, araddr;
    logic [2:0]  awprot, arprot;
    logic        awvalid, wvalid, bready, arvalid, rready;
    logic        awready, wready, bvalid, arready, rvalid;
    logic [31:0] wdata, rdata, result;
    logic [3:0]  wstrb;
    logic [1:0]  bresp, rresp;

    int n_vec = 0;
    int n_err = 0;

    logic [31:0] m_reg [4];

    always #5 clk = ~clk;

    math_axil_regs dut (
        .S_AXI_ACLK(clk), .S_AXI_ARESETN(arst_n),
        .S_AXI_AWADDR(awaddr), .S_AXI_AWPROT(awprot), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
        .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
        .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
        .S_AXI_ARADDR(araddr), .S_AXI_ARPROT(arprot), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
        .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready),
        .result_o(result)
    );

    typedef struct {
        bit          wr;
        logic [4:0]  addr;
        logic [31:0] data;
        logic [3:0]  strb;
        logic [31:0] exp_data;
        logic [1:0]  exp_resp;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk_w(input logic [4:0] a, input logic [31:0] d,
                                  input logic [3:0] s, input logic [1:0] r);
        vec_t v;
        v.wr = 1'b1; v.addr = a; v.data = d; v.strb = s; v.exp_data = 32'h0; v.exp_resp = r;
        return v;
    endfunction

    function automatic vec_t mk_r(input logic [4:0] a, input logic [31:0] e, input logic [1:0] r);
        vec_t v;
        v.wr = 1'b0; v.addr = a; v.data = 32'h0; v.strb = 4'h0; v.exp_data = e; v.exp_resp = r;
        return v;
    endfunction

    // Reference model: the arithmetic the result register is defined to hold.
    function automatic logic [31:0] m_result();
        int unsigned a, b;
        a = m_reg[0];
        b = m_reg[1];
        case (m_reg[3][1:0])
            2'd0:    return a + b;
            2'd1:    return a - b;
            2'd2:    return a * b;
            default: return a & b;
        endcase
    endfunction

    function automatic void m_write(input logic [4:0] a, input logic [31:0] d, input logic [3:0] s);
        int idx;
        idx = int'(a[4:2]);
        if (idx < 4) begin
            for (int i = 0; i < 4; i++) if (s[i]) m_reg[idx][i*8 +: 8] = d[i*8 +: 8];
        end
    endfunction

    function automatic void m_read(input logic [4:0] a, output logic [31:0] d, output logic [1:0] r);
        int idx;
        idx = int'(a[4:2]);
        r = 2'b00;
        if (idx < 4)       d = m_reg[idx];
        else if (idx == 4) d = m_result();
        else begin d = 32'h0; r = 2'b10; end
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic axi_write(input logic [4:0] a, input logic [31:0] d, input logic [3:0] s,
                             output logic [1:0] resp);
        bit aw_done, w_done, aw_hs, w_hs;
        int n;
        aw_done = 1'b0; w_done = 1'b0; n = 0;
        @(negedge clk);
        awaddr = a; awprot = 3'($urandom); awvalid = 1'b1;
        wdata = d; wstrb = s; wvalid = 1'b1;
        while (!(aw_done && w_done) && n < 100) begin
            aw_hs = awvalid && awready;
            w_hs  = wvalid && wready;
            @(negedge clk);
            if (aw_hs) begin aw_done = 1'b1; awvalid = 1'b0; end
            if (w_hs)  begin w_done  = 1'b1; wvalid  = 1'b0; end
            n++;
        end
        awvalid = 1'b0; wvalid = 1'b0;
        if (n >= 100) chk("write_accept_timeout", 32'(n), 32'd0);
        bready = 1'b1;
        n = 0;
        while (!bvalid && n < 100) begin @(negedge clk); n++; end
        if (n >= 100) chk("bvalid_timeout", 32'(n), 32'd0);
        resp = bresp;
        @(negedge clk);
        bready = 1'b0;
    endtask

    task automatic axi_read(input logic [4:0] a, output logic [31:0] d, output logic [1:0] resp);
        bit hs;
        int n;
        n = 0;
        @(negedge clk);
        araddr = a; arprot = 3'($urandom); arvalid = 1'b1;
        hs = 1'b0;
        while (!hs && n < 100) begin
            hs = arvalid && arready;
            @(negedge clk);
            n++;
        end
        arvalid = 1'b0;
        if (n >= 100) chk("read_accept_timeout", 32'(n), 32'd0);
        rready = 1'b1;
        n = 0;
        while (!rvalid && n < 100) begin @(negedge clk); n++; end
        if (n >= 100) chk("rvalid_timeout", 32'(n), 32'd0);
        d = rdata; resp = rresp;
        @(negedge clk);
        rready = 1'b0;
    endtask

    // Write whose register update lands on the same edge as a read's AR handshake.
    task automatic same_cycle(input string nm, input logic [4:0] wa, input logic [31:0] wd,
                              input logic [4:0] ra);
        logic [31:0] exp_d;
        logic [1:0]  exp_r;
        m_read(ra, exp_d, exp_r);
        @(negedge clk);
        chk({nm, "_ready"}, 32'({awready, wready, arready}), 32'd7);
        awaddr = wa; awvalid = 1'b1; wdata = wd; wstrb = 4'hF; wvalid = 1'b1;
        @(negedge clk);
        awvalid = 1'b0; wvalid = 1'b0; araddr = ra; arvalid = 1'b1;
        @(negedge clk);
        arvalid = 1'b0;
        chk({nm, "_bvalid"}, 32'(bvalid), 32'd1);
        chk({nm, "_rvalid"}, 32'(rvalid), 32'd1);
        chk({nm, "_rdata"}, rdata, exp_d);
        bready = 1'b1; rready = 1'b1;
        @(negedge clk);
        bready = 1'b0; rready = 1'b0;
        m_write(wa, wd, 4'hF);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] d, exp_d;
        logic [1:0]  r, exp_r;
        int          idx;
        logic [4:0]  a;

        arst_n = 1'b0;
        awaddr = 5'd0; araddr = 5'd0; awprot = 3'd0; arprot = 3'd0;
        awvalid = 1'b0; wvalid = 1'b0; bready = 1'b0; arvalid = 1'b0; rready = 1'b0;
        wdata = 32'h0; wstrb = 4'h0;
        for (int i = 0; i < 4; i++) m_reg[i] = 32'h0;

        repeat (3) @(negedge clk);
        chk("rst_readies", 32'({awready, wready, arready}), 32'd0);
        chk("rst_valids", 32'({bvalid, rvalid}), 32'd0);
        chk("rst_resps", 32'({bresp, rresp}), 32'd0);
        chk("rst_rdata", rdata, 32'h0);
        chk("rst_result", result, 32'h0);
        arst_n = 1'b1;
        @(negedge clk);

        // Directed table: readback, op select, strobes, error responses, ADDR[1:0] ignored.
        tbl.push_back(mk_w(5'h00, 32'h1, 4'hF, 2'b00));
        tbl.push_back(mk_w(5'h04, 32'h2, 4'hF, 2'b00));
        tbl.push_back(mk_w(5'h08, 32'h3, 4'hF, 2'b00));
        tbl.push_back(mk_w(5'h0C, 32'h4, 4'hF, 2'b00));
        tbl.push_back(mk_r(5'h00, 32'h1, 2'b00));
        tbl.push_back(mk_r(5'h04, 32'h2, 2'b00));
        tbl.push_back(mk_r(5'h08, 32'h3, 2'b00));
        tbl.push_back(mk_r(5'h0C, 32'h4, 2'b00));
        tbl.push_back(mk_w(5'h00, 32'h5, 4'hF, 2'b00));
        tbl.push_back(mk_w(5'h04, 32'h7, 4'hF, 2'b00));
        tbl.push_back(mk_w(5'h0C, 32'h0, 4'hF, 2'b00));
        tbl.push_back(mk_r(5'h10, 32'h0000_000C, 2'b00));
        tbl.push_back(mk_w(5'h0C, 32'h1, 4'hF, 2'b00));
        tbl.push_back(mk_r(5'h10, 32'hFFFF_FFFE, 2'b00));
        tbl.push_back(mk_w(5'h0C, 32'h2, 4'hF, 2'b00));
        tbl.push_back(mk_r(5'h10, 32'h0000_0023, 2'b00));
        tbl.push_back(mk_w(5'h0C, 32'h3, 4'hF, 2'b00));
        tbl.push_back(mk_r(5'h10, 32'h0000_0005, 2'b00));
        tbl.push_back(mk_w(5'h08, 32'h1122_3344, 4'hF, 2'b00));
        tbl.push_back(mk_w(5'h08, 32'hAABB_CCDD, 4'h5, 2'b00));
        tbl.push_back(mk_r(5'h08, 32'h11BB_33DD, 2'b00));
        tbl.push_back(mk_w(5'h10, 32'hDEAD_BEEF, 4'hF, 2'b10));
        tbl.push_back(mk_w(5'h14, 32'hDEAD_BEEF, 4'hF, 2'b10));
        tbl.push_back(mk_r(5'h10, 32'h0000_0005, 2'b00));
        tbl.push_back(mk_r(5'h0C, 32'h0000_0003, 2'b00));
        tbl.push_back(mk_r(5'h18, 32'h0000_0000, 2'b10));
        tbl.push_back(mk_r(5'h1C, 32'h0000_0000, 2'b10));
        tbl.push_back(mk_r(5'h03, 32'h0000_0005, 2'b00));

        foreach (tbl[i]) begin
            if (tbl[i].wr) begin
                axi_write(tbl[i].addr, tbl[i].data, tbl[i].strb, r);
                chk($sformatf("tbl%0d_bresp", i), 32'(r), 32'(tbl[i].exp_resp));
                m_write(tbl[i].addr, tbl[i].data, tbl[i].strb);
            end else begin
                axi_read(tbl[i].addr, d, r);
                chk($sformatf("tbl%0d_rdata", i), d, tbl[i].exp_data);
                chk($sformatf("tbl%0d_rresp", i), 32'(r), 32'(tbl[i].exp_resp));
                if (tbl[i].addr == 5'h10) chk($sformatf("tbl%0d_result_o", i), result, tbl[i].exp_data);
            end
        end

        // W three cycles ahead of AW, then BREADY held low for four cycles.
        @(negedge clk);
        wdata = 32'hCAFE_F00D; wstrb = 4'hF; wvalid = 1'b1;
        chk("early_w_wready", 32'(wready), 32'd1);
        @(negedge clk);
        wvalid = 1'b0;
        repeat (2) @(negedge clk);
        chk("early_w_awready", 32'(awready), 32'd1);
        awaddr = 5'h08; awvalid = 1'b1;
        @(negedge clk);
        awvalid = 1'b0;
        @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("hold%0d_bvalid", k), 32'(bvalid), 32'd1);
            chk($sformatf("hold%0d_readies", k), 32'({awready, wready}), 32'd0);
            @(negedge clk);
        end
        chk("hold_bresp", 32'(bresp), 32'd0);
        bready = 1'b1;
        @(negedge clk);
        bready = 1'b0;
        chk("hold_bvalid_clr", 32'(bvalid), 32'd0);
        m_write(5'h08, 32'hCAFE_F00D, 4'hF);
        axi_read(5'h08, d, r);
        chk("hold_readback", d, 32'hCAFE_F00D);
        axi_write(5'h08, 32'h0BAD_BEEF, 4'hF, r);
        chk("next_write_bresp", 32'(r), 32'd0);
        m_write(5'h08, 32'h0BAD_BEEF, 4'hF);
        axi_read(5'h08, d, r);
        chk("next_write_readback", d, 32'h0BAD_BEEF);

        // Same-edge read sees pre-write register and pre-update result.
        same_cycle("sc_reg", 5'h04, 32'h0000_0100, 5'h04);
        same_cycle("sc_res", 5'h00, 32'h0000_0F0F, 5'h10);
        axi_read(5'h10, d, r);
        chk("sc_res_after", d, m_result());

        // Randomized traffic against the model.
        for (int k = 0; k < 150; k++) begin
            idx = $urandom_range(0, 7);
            a = {idx[2:0], 2'($urandom)};
            if ($urandom_range(0, 1) == 1) begin
                d = $urandom;
                wstrb = 4'($urandom);
                axi_write(a, d, wstrb, r);
                chk($sformatf("rnd%0d_bresp", k), 32'(r), (idx < 4) ? 32'd0 : 32'd2);
                m_write(a, d, wstrb);
            end else begin
                m_read(a, exp_d, exp_r);
                axi_read(a, d, r);
                chk($sformatf("rnd%0d_rdata", k), d, exp_d);
                chk($sformatf("rnd%0d_rresp", k), 32'(r), 32'(exp_r));
            end
            chk($sformatf("rnd%0d_result_o", k), result, m_result());
        end

        // Reset with both responses pending.
        @(negedge clk);
        awaddr = 5'h00; awvalid = 1'b1; wdata = 32'h1234_5678; wstrb = 4'hF; wvalid = 1'b1;
        araddr = 5'h04; arvalid = 1'b1; bready = 1'b0; rready = 1'b0;
        @(negedge clk);
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
        @(negedge clk);
        chk("pre_rst_valids", 32'({bvalid, rvalid}), 32'd3);
        arst_n = 1'b0;
        @(negedge clk);
        chk("mid_rst_valids", 32'({bvalid, rvalid}), 32'd0);
        chk("mid_rst_readies", 32'({awready, wready, arready}), 32'd0);
        chk("mid_rst_rdata", rdata, 32'h0);
        chk("mid_rst_result", result, 32'h0);
        arst_n = 1'b1; bready = 1'b1; rready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk($sformatf("stale%0d", k), 32'({bvalid, rvalid}), 32'd0);
        end
        bready = 1'b0; rready = 1'b0;
        for (int i = 0; i < 4; i++) m_reg[i] = 32'h0;
        for (int i = 0; i < 5; i++) begin
            axi_read(5'(i * 4), d, r);
            chk($sformatf("post_rst_reg%0d", i), d, 32'h0);
            chk($sformatf("post_rst_resp%0d", i), 32'(r), 32'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
